dram_responder: RTL and testbench

Memory-side responder that serves the read/write request port driven by the layer engines (conv, pool, full-connection) and maps it onto a single-port, 1-cycle-latency SRAM macro. Engines may assert read and write in the same cycle, so writes are parked in a small forwarding write buffer and drained into the SRAM whenever the read path is idle or the buffer is full. Read data returns with fixed latency and a valid strobe, which is the engines' `dram_valid`.

---
 rtl/dram_pkg.sv | 15 +
 rtl/dram_wbuf.sv | 76 +++++++
 rtl/dram_responder.sv | 108 ++++++++++
 tb/tb_dram_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared constants for the DRAM responder and the benches that drive it.
// Holds the default widths, the SRAM and responder latencies, and the layer-engine memory-map bases.
package dram_pkg;
    localparam int DATA_WIDTH      = 32;
    localparam int ADDR_WIDTH      = 18;
    localparam int WBUF_DEPTH_DEF  = 4;
    localparam int SRAM_LATENCY    = 1;
    localparam int RSP_LATENCY     = 2;

    localparam int WEIGHT_BASE     = 0;
    localparam int BIAS_BASE0      = 48000;
    localparam int BIAS_BASE1      = 51200;
    localparam int IFMAP_BASE      = 65536;
    localparam int OFMAP_BASE      = 131072;
endpackage

// File: rtl/dram_wbuf.sv
// Circular write buffer with a parallel address match that returns the youngest hit.
// Latency: push visible to pop/match the cycle after it is written; match is combinational.
// Backpressure: full_o is advisory; the owner must pop in the same cycle it pushes while full.
module dram_wbuf
    import dram_pkg::*;
#(
    parameter int DW    = DATA_WIDTH,
    parameter int AW    = ADDR_WIDTH,
    parameter int DEPTH = WBUF_DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          srstn,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    input  logic [AW-1:0] match_addr_i,
    output logic          hit_o,
    output logic [DW-1:0] hit_data_o
);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] idx;

    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    always_comb begin
        count_d = count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i)  head_q <= head_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Walk oldest to youngest so the last matching entry overrides earlier ones.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx] == match_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
endmodule

// File: rtl/dram_responder.sv
// Serves engine read/write requests onto a 1-cycle single-port SRAM, parking writes in a forwarding buffer.
// Latency: read accepted at t returns rdata/rvalid at t+2; writes drain from t+1 when the read path is idle.
// Backpressure: busy (buffer full) rejects reads and flags err_rd_drop; writes are always accepted.
module dram_responder
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH = dram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = dram_pkg::ADDR_WIDTH,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  req_rd,
    input  logic [ADDR_WIDTH-1:0] req_addr_rd,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr_wr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  busy,
    output logic                  err_rd_drop,
    output logic                  mem_cen,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int CW = $clog2(WBUF_DEPTH) + 1;

    logic                  full, empty, rd_acc, drain, hit;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data, hit_data;
    logic [CW-1:0]         count;

    logic                  s1_vld_q, s1_hit_q, rvalid_q, err_q, err_d;
    logic [DATA_WIDTH-1:0] s1_fwd_q, rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    dram_wbuf #(
        .DW    (DATA_WIDTH),
        .AW    (ADDR_WIDTH),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk          (clk),
        .srstn        (srstn),
        .push_i       (req_wr),
        .push_addr_i  (req_addr_wr),
        .push_data_i  (req_wdata),
        .pop_i        (drain),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty),
        .match_addr_i (req_addr_rd),
        .hit_o        (hit),
        .hit_data_o   (hit_data)
    );

    // Reads own the port; the buffer drains only in cycles without an accepted read.
    always_comb begin
        rd_acc      = req_rd & ~full;
        drain       = ~rd_acc & ~empty;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rd_acc) begin
            mem_addr_d = req_addr_rd;
        end else if (drain) begin
            mem_addr_d  = head_addr;
            mem_wdata_d = head_data;
        end
        rdata_d = rdata_q;
        if (s1_vld_q) rdata_d = s1_hit_q ? s1_fwd_q : mem_rdata;
        err_d = err_q | (req_rd & full);
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            s1_vld_q    <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_fwd_q    <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            s1_vld_q    <= rd_acc;
            s1_hit_q    <= rd_acc & hit;
            s1_fwd_q    <= hit_data;
            rvalid_q    <= s1_vld_q;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_cen     = rd_acc | drain;
    assign mem_wen     = drain;
    assign mem_addr    = mem_addr_d;
    assign mem_wdata   = mem_wdata_d;
    assign busy        = full;
    assign err_rd_drop = err_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder with a behavioural 1-cycle SRAM.
module tb_dram_responder;
    import dram_pkg::*;

    logic        clk = 1'b0;
    logic        srstn;
    logic        req_rd, req_wr;
    logic [17:0] req_addr_rd, req_addr_wr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        rvalid, busy, err_rd_drop, mem_cen, mem_wen;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] sram [int];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    dram_responder dut (
        .clk         (clk),
        .srstn       (srstn),
        .req_rd      (req_rd),
        .req_addr_rd (req_addr_rd),
        .req_wr      (req_wr),
        .req_addr_wr (req_addr_wr),
        .req_wdata   (req_wdata),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .busy        (busy),
        .err_rd_drop (err_rd_drop),
        .mem_cen     (mem_cen),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_cen) begin
            if (mem_wen) sram[int'(mem_addr)] = mem_wdata;
            else mem_rdata <= sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : 32'h0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid) begin
            if (sbq.size() == 0) begin
                chk("rvalid_unexpected", {63'd0, rvalid}, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rd_cycle", 64'(e.cyc), 64'(cyc));
                chk("rd_data", {32'd0, rdata}, {32'd0, e.dat});
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input int ard, input logic wr, input int awr, input logic [31:0] wd);
        req_rd      = rd;
        req_addr_rd = 18'(ard);
        req_wr      = wr;
        req_addr_wr = 18'(awr);
        req_wdata   = wd;
    endtask

    task automatic expect_rd(input logic [31:0] d);
        exp_t e;
        e.cyc = cyc + 2;
        e.dat = d;
        sbq.push_back(e);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rdata"}, {32'd0, rdata}, 64'd0);
        chk({tag, "_rvalid"}, {63'd0, rvalid}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_err"}, {63'd0, err_rd_drop}, 64'd0);
        chk({tag, "_cen"}, {63'd0, mem_cen}, 64'd0);
        chk({tag, "_wen"}, {63'd0, mem_wen}, 64'd0);
        chk({tag, "_addr"}, {46'd0, mem_addr}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        srstn = 1'b0;
        drive(0, 0, 0, 0, 0);
        sram[IFMAP_BASE] = 32'h0000_1234;
        sram[200]        = 32'd7;
        repeat (2) nxt();
        chk_idle_outputs("reset");
        srstn = 1'b1;
        repeat (2) nxt();

        // Single read from SRAM.
        drive(1, IFMAP_BASE, 0, 0, 0);
        expect_rd(32'h1234);
        #1;
        chk("rd1_cen", {63'd0, mem_cen}, 64'd1);
        chk("rd1_wen", {63'd0, mem_wen}, 64'd0);
        chk("rd1_addr", {46'd0, mem_addr}, 64'(IFMAP_BASE));
        nxt(); drive(0, 0, 0, 0, 0);
        repeat (3) nxt();

        // Idle drain of one write.
        drive(0, 0, 1, OFMAP_BASE, 32'h55);
        #1;
        chk("drain_t0_cen", {63'd0, mem_cen}, 64'd0);
        nxt(); drive(0, 0, 0, 0, 0);
        #1;
        chk("drain_t1_cen", {63'd0, mem_cen}, 64'd1);
        chk("drain_t1_wen", {63'd0, mem_wen}, 64'd1);
        chk("drain_t1_addr", {46'd0, mem_addr}, 64'(OFMAP_BASE));
        chk("drain_t1_wdata", {32'd0, mem_wdata}, 64'h55);
        nxt();
        chk("drain_t2_cen", {63'd0, mem_cen}, 64'd0);
        chk("drain_t2_addr_hold", {46'd0, mem_addr}, 64'(OFMAP_BASE));
        chk("drain_t2_wdata_hold", {32'd0, mem_wdata}, 64'h55);
        nxt(); drive(1, OFMAP_BASE, 0, 0, 0); expect_rd(32'h55);
        nxt(); drive(0, 0, 0, 0, 0);
        repeat (3) nxt();

        // Forwarding under continuous reads: youngest buffered write wins.
        drive(1, IFMAP_BASE, 1, OFMAP_BASE + 3, 32'hAA); expect_rd(32'h1234);
        nxt(); drive(1, IFMAP_BASE, 1, OFMAP_BASE + 3, 32'hBB); expect_rd(32'h1234);
        nxt(); drive(1, OFMAP_BASE + 3, 0, 0, 0); expect_rd(32'hBB);
        #1;
        chk("fwd_wen_blocked", {63'd0, mem_wen}, 64'd0);
        chk("fwd_sram_unwritten", {63'd0, sram.exists(OFMAP_BASE + 3) ? 1'b1 : 1'b0}, 64'd0);
        nxt(); drive(0, 0, 0, 0, 0);
        repeat (4) nxt();
        drive(1, OFMAP_BASE + 3, 0, 0, 0); expect_rd(32'hBB);
        nxt(); drive(0, 0, 0, 0, 0);
        repeat (3) nxt();

        // Fill the buffer while reads hold the port.
        for (int i = 0; i < 4; i++) begin
            drive(1, IFMAP_BASE, 1, OFMAP_BASE + 8 + i, 32'h10 + 32'(i));
            expect_rd(32'h1234);
            #1;
            chk("fill_busy_low", {63'd0, busy}, 64'd0);
            nxt();
        end
        drive(1, IFMAP_BASE, 1, OFMAP_BASE + 12, 32'h14);
        #1;
        chk("full_busy", {63'd0, busy}, 64'd1);
        chk("full_cen", {63'd0, mem_cen}, 64'd1);
        chk("full_wen", {63'd0, mem_wen}, 64'd1);
        chk("full_addr", {46'd0, mem_addr}, 64'(OFMAP_BASE + 8));
        chk("full_wdata", {32'd0, mem_wdata}, 64'h10);
        chk("full_err_pre", {63'd0, err_rd_drop}, 64'd0);
        nxt(); drive(0, 0, 0, 0, 0);
        #1;
        chk("full_busy_hold", {63'd0, busy}, 64'd1);
        chk("full_err_set", {63'd0, err_rd_drop}, 64'd1);
        nxt();
        chk("full_busy_clear", {63'd0, busy}, 64'd0);
        repeat (4) nxt();
        chk("err_sticky", {63'd0, err_rd_drop}, 64'd1);
        drive(1, OFMAP_BASE + 12, 0, 0, 0); expect_rd(32'h14);
        nxt(); drive(1, OFMAP_BASE + 8, 0, 0, 0); expect_rd(32'h10);
        nxt(); drive(1, OFMAP_BASE + 11, 0, 0, 0); expect_rd(32'h13);
        nxt(); drive(0, 0, 0, 0, 0);
        repeat (3) nxt();

        // Same-cycle read and write to one address.
        drive(1, 200, 1, 200, 32'd9); expect_rd(32'd7);
        nxt(); drive(1, 200, 0, 0, 0); expect_rd(32'd9);
        nxt(); drive(0, 0, 0, 0, 0);
        repeat (3) nxt();
        chk("err_sticky_late", {63'd0, err_rd_drop}, 64'd1);

        // Reset with reads in flight and writes buffered.
        for (int i = 0; i < 3; i++) begin
            drive(1, IFMAP_BASE, 1, 300 + i, 32'hE0 + 32'(i));
            if (i == 0) expect_rd(32'h1234);
            nxt();
        end
        drive(0, 0, 0, 0, 0);
        srstn = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        repeat (2) nxt();
        srstn = 1'b1;
        repeat (6) nxt();
        for (int i = 0; i < 3; i++)
            chk("rst_lost_write", {63'd0, sram.exists(300 + i) ? 1'b1 : 1'b0}, 64'd0);
        drive(1, 300, 0, 0, 0); expect_rd(32'h0);
        nxt(); drive(0, 0, 0, 0, 0);
        repeat (5) nxt();
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
